reg_bank: RTL and testbench

Parametrised bank of `NUM_REGS` memory-mapped peripheral registers of `DATA_W` bits, each with MAIN/SET/CLR/INV address aliases. Every bit is classed as software read-write, clear-only status (set by hardware events), or read-only (hardware-driven). It sits between the peripheral bus slave port and a peripheral's control logic and replaces hand-written per-peripheral register decode. It also provides per-register write strobes and status-pending interrupts.

---
 rtl/reg_bank_pkg.sv | 68 ++++++
 rtl/reg_bank_cell.sv | 43 ++++
 rtl/reg_bank.sv | 110 +++++++++++
 tb/tb_reg_bank.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared register-bank types and per-bit next-value helpers.
// Helpers work on full bus-width vectors; callers truncate to their register width.
package registers;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        ACC_MAIN = 2'd0,
        ACC_SET  = 2'd1,
        ACC_CLR  = 2'd2,
        ACC_INV  = 2'd3
    } reg_access_t;

    typedef enum logic [1:0] {RW, STATUS, RO} reg_bit_class_t;

    typedef enum logic {IDLE, RESP} bus_state_t;

    function automatic logic [BUS_W-1:0] writeval(input logic [BUS_W-1:0] cur,
                                                  input logic [BUS_W-1:0] wr,
                                                  input reg_access_t acc);
        case (acc)
            ACC_MAIN: return wr;
            ACC_SET:  return cur | wr;
            ACC_CLR:  return cur & ~wr;
            default:  return cur ^ wr;
        endcase
    endfunction

    // Status bits can only be cleared by software; SET is a no-op.
    function automatic logic [BUS_W-1:0] clearonly(input logic [BUS_W-1:0] cur,
                                                   input logic [BUS_W-1:0] wr,
                                                   input reg_access_t acc);
        case (acc)
            ACC_MAIN: return cur & wr;
            ACC_SET:  return cur;
            default:  return cur & ~wr;
        endcase
    endfunction

    function automatic reg_bit_class_t bit_class(input logic rw, input logic st);
        if (st)      return STATUS;
        else if (rw) return RW;
        else         return RO;
    endfunction

    function automatic logic [BUS_W-1:0] masked_next(input logic [BUS_W-1:0] cur,
                                                     input logic [BUS_W-1:0] wr,
                                                     input logic [BUS_W-1:0] hwset,
                                                     input logic [BUS_W-1:0] hwro,
                                                     input logic [BUS_W-1:0] rw_mask,
                                                     input logic [BUS_W-1:0] st_mask,
                                                     input reg_access_t acc,
                                                     input logic wr_en);
        logic [BUS_W-1:0] sw_rw, sw_st, nxt;
        sw_rw = wr_en ? writeval(cur, wr, acc) : cur;
        sw_st = wr_en ? clearonly(cur, wr, acc) : cur;
        nxt   = '0;
        for (int b = 0; b < BUS_W; b++) begin
            case (bit_class(rw_mask[b], st_mask[b]))
                STATUS:  nxt[b] = sw_st[b] | hwset[b];
                RW:      nxt[b] = sw_rw[b];
                default: nxt[b] = hwro[b];
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// One DATA_W-bit register with per-bit RW / status / read-only behaviour.
module reg_bank_cell
    import registers::*;
#(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    parameter logic [DATA_W-1:0] RW_MASK     = '1,
    parameter logic [DATA_W-1:0] STATUS_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  reg_access_t       acc,
    input  logic [BUS_W-1:0]  wdata,
    input  logic [DATA_W-1:0] hw_set,
    input  logic [DATA_W-1:0] hw_ro,
    output logic [DATA_W-1:0] q,
    output logic              irq
);
    localparam logic [BUS_W-1:0] RW_EXT = BUS_W'(RW_MASK);
    localparam logic [BUS_W-1:0] ST_EXT = BUS_W'(STATUS_MASK);

    logic [BUS_W-1:0] nxt_full;

    assign nxt_full = masked_next(BUS_W'(q), wdata, BUS_W'(hw_set), BUS_W'(hw_ro),
                                  RW_EXT, ST_EXT, acc, wr_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RESET_VAL;
        else     q <= DATA_W'(nxt_full);
    end

    assign irq = |(q & STATUS_MASK);

    // Bus bits above the register width carry nothing for this cell.
    generate
        if (DATA_W < BUS_W) begin : g_pad
            logic unused_hi;
            assign unused_hi = ^{nxt_full[BUS_W-1:DATA_W], wdata[BUS_W-1:DATA_W]};
        end
    endgenerate

endmodule

// File: rtl/reg_bank.sv
// Memory-mapped register bank: bus FSM, address decode, read mux and cell array.
module reg_bank
    import registers::*;
#(
    parameter int                         NUM_REGS    = 4,
    parameter int                         DATA_W      = 32,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RW_MASK     = '1,
    parameter logic [NUM_REGS*DATA_W-1:0] STATUS_MASK = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bus_req,
    input  logic                         bus_we,
    input  logic [$clog2(NUM_REGS)+3:0]  bus_addr,
    input  logic [31:0]                  bus_wdata,
    output logic [31:0]                  bus_rdata,
    output logic                         bus_ready,
    output logic                         bus_err,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_ro,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic [NUM_REGS-1:0]          irq
);
    localparam int AW    = $clog2(NUM_REGS) + 4;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    bus_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              accept;
    reg_access_t       acc;
    logic [NUM_REGS-1:0] wr_en;
    logic [DATA_W-1:0] q_arr [NUM_REGS];
    logic [BUS_W-1:0]  rd_val;
    logic              unused_addr;

    generate
        if (NUM_REGS > 1) begin : g_idx
            assign idx = bus_addr[AW-1:4];
        end else begin : g_idx1
            assign idx = 1'b0;
        end
    endgenerate

    assign unused_addr = ^bus_addr[1:0];
    assign acc         = reg_access_t'(bus_addr[3:2]);
    assign in_range    = int'(idx) < NUM_REGS;
    assign accept      = (state == IDLE) && bus_req;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
            assign wr_en[i] = accept && bus_we && in_range && (idx == IDX_W'(i));

            reg_bank_cell #(
                .DATA_W     (DATA_W),
                .RESET_VAL  (RESET_VALS[i*DATA_W +: DATA_W]),
                .RW_MASK    (RW_MASK[i*DATA_W +: DATA_W]),
                .STATUS_MASK(STATUS_MASK[i*DATA_W +: DATA_W])
            ) u_cell (
                .clk   (clk),
                .rst   (rst),
                .wr_en (wr_en[i]),
                .acc   (acc),
                .wdata (bus_wdata),
                .hw_set(hw_set[i*DATA_W +: DATA_W]),
                .hw_ro (hw_ro[i*DATA_W +: DATA_W]),
                .q     (q_arr[i]),
                .irq   (irq[i])
            );

            assign reg_q[i*DATA_W +: DATA_W] = q_arr[i];
        end
    endgenerate

    always_comb begin
        rd_val = '0;
        if (in_range) rd_val = BUS_W'(q_arr[idx]);
    end

    // Read data is taken from pre-write contents at the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus_ready <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
            wr_strobe <= '0;
        end else begin
            bus_ready <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
            wr_strobe <= '0;
            case (state)
                IDLE: begin
                    if (bus_req) begin
                        state     <= RESP;
                        bus_ready <= 1'b1;
                        bus_err   <= !in_range;
                        wr_strobe <= wr_en;
                        if (!bus_we) bus_rdata <= rd_val;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench: directed literal checks plus randomized traffic vs a per-bit model.
module tb_reg_bank;
    localparam int NR = 5;
    localparam int DW = 16;
    localparam int AW = 7;
    localparam logic [NR*DW-1:0] RESET_VALS  = {16'h0000, 16'h3C5A, 16'h0000, 16'h0000, 16'h00A5};
    localparam logic [NR*DW-1:0] RW_MASK     = {16'h00FF, 16'hFF00, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    localparam logic [NR*DW-1:0] STATUS_MASK = {16'h0000, 16'h0F00, 16'h00FF, 16'h0000, 16'h0000};

    logic clk = 0;
    logic rst;
    logic bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic bus_ready, bus_err;
    logic [NR*DW-1:0] hw_set, hw_ro, reg_q;
    logic [NR-1:0] wr_strobe, irq;

    int checks = 0;
    int errors = 0;

    reg_bank #(
        .NUM_REGS(NR), .DATA_W(DW), .RESET_VALS(RESET_VALS),
        .RW_MASK(RW_MASK), .STATUS_MASK(STATUS_MASK)
    ) dut (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ready(bus_ready), .bus_err(bus_err), .hw_set(hw_set), .hw_ro(hw_ro),
        .reg_q(reg_q), .wr_strobe(wr_strobe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: registers as an array, each bit evaluated by its class rules.
    logic [DW-1:0] m_reg [NR];
    logic          m_busy, e_ready, e_err;
    logic [31:0]   e_rdata;
    logic [NR-1:0] e_strobe;
    logic          m_acc, m_wr, m_c, m_w, m_n;
    int            m_ix;
    logic [1:0]    m_t;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) m_reg[i] = RESET_VALS[i*DW +: DW];
            m_busy = 0; e_ready = 0; e_err = 0; e_rdata = 0; e_strobe = 0;
        end else begin
            m_acc = !m_busy && bus_req;
            m_ix  = int'(bus_addr[6:4]);
            m_t   = bus_addr[3:2];
            e_ready  = m_acc;
            e_err    = m_acc && (m_ix >= NR);
            e_rdata  = 0;
            e_strobe = 0;
            if (m_acc && !bus_we && m_ix < NR) e_rdata = 32'(m_reg[m_ix]);
            if (m_acc && bus_we && m_ix < NR) e_strobe[m_ix] = 1'b1;
            for (int i = 0; i < NR; i++) begin
                m_wr = m_acc && bus_we && (m_ix == i);
                for (int b = 0; b < DW; b++) begin
                    m_c = m_reg[i][b];
                    m_w = bus_wdata[b];
                    if (STATUS_MASK[i*DW+b]) begin
                        m_n = m_c;
                        if (m_wr) m_n = (m_t == 0) ? (m_c & m_w) : (m_t == 1) ? m_c : (m_c & !m_w);
                        m_n = m_n | hw_set[i*DW+b];
                    end else if (RW_MASK[i*DW+b]) begin
                        m_n = m_c;
                        if (m_wr)
                            case (m_t)
                                2'd0: m_n = m_w;
                                2'd1: m_n = m_c | m_w;
                                2'd2: m_n = m_c & !m_w;
                                default: m_n = m_c ^ m_w;
                            endcase
                    end else begin
                        m_n = hw_ro[i*DW+b];
                    end
                    m_reg[i][b] = m_n;
                end
            end
            m_busy = m_acc;
        end
    end

    logic [NR*DW-1:0] e_q;
    logic [NR-1:0]    e_irq;
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            e_q[i*DW +: DW] = m_reg[i];
            e_irq[i] = |(m_reg[i] & STATUS_MASK[i*DW +: DW]);
        end
        chk("ready", bus_ready, e_ready);
        chk("err", bus_err, e_err);
        chk("rdata", bus_rdata, e_rdata);
        chk("strobe", wr_strobe, e_strobe);
        chk("reg_q", reg_q, e_q);
        chk("irq", irq, e_irq);
    end

    function automatic logic [DW-1:0] rq(input int i);
        return reg_q[i*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one access from IDLE; returns in the response cycle.
    task automatic access(input logic we, input int ix, input logic [1:0] t, input logic [31:0] wd);
        logic [2:0] ixb;
        logic [1:0] lo;
        ixb = 3'(ix);
        lo  = 2'($urandom);
        bus_req = 1; bus_we = we; bus_addr = {ixb, t, lo}; bus_wdata = wd;
        tick();
        bus_req = 0;
    endtask

    logic [NR*DW-1:0] snap;

    initial begin
        rst = 0; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
        hw_set = 0; hw_ro = {NR{16'h1234}};
        #1 rst = 1;
        #2;
        chk("rst_reg0", rq(0), 16'h00A5);
        chk("rst_reg3", rq(3), 16'h3C5A);
        chk("rst_ready", bus_ready, 0);
        chk("rst_irq3", irq[3], 1);
        @(posedge clk); @(posedge clk); #1 rst = 0;
        tick();
        chk("ro_load", rq(3), 16'h3C34);

        access(1, 1, 2'd0, 32'h0000_00F0); tick();
        access(1, 1, 2'd1, 32'h0000_000F);
        chk("set_val", rq(1), 16'h00FF);
        chk("set_rdy", bus_ready, 1);
        chk("set_stb", wr_strobe, 5'b00010);
        tick();
        access(1, 1, 2'd2, 32'h0000_003C);
        chk("clr_val", rq(1), 16'h00C3);
        tick();
        access(1, 1, 2'd3, 32'h0000_00FF);
        chk("inv_val", rq(1), 16'h003C);
        chk("inv_stb", wr_strobe, 5'b00010);
        tick();

        hw_set[2*DW +: DW] = 16'h000C; tick(); hw_set = 0;
        chk("hwset_val", rq(2), 16'h000C);
        chk("hwset_irq", irq[2], 1);
        access(1, 2, 2'd0, 32'h0000_0008);
        chk("st_main", rq(2), 16'h0008);
        tick();
        hw_set[2*DW +: DW] = 16'h0004;
        access(1, 2, 2'd2, 32'h0000_0004);
        hw_set = 0;
        chk("st_clr_vs_set", rq(2), 16'h000C);
        tick();
        access(1, 2, 2'd2, 32'h0000_000C);
        chk("st_clr_all", rq(2), 16'h0000);
        chk("st_irq_off", irq[2], 0);
        tick();

        access(0, 1, 2'd3, 32'hFFFF_FFFF);
        chk("rd_inv_data", bus_rdata, 32'h0000_003C);
        chk("rd_inv_stb", wr_strobe, 0);
        chk("rd_inv_keep", rq(1), 16'h003C);
        tick();

        snap = reg_q;
        access(1, 5, 2'd0, 32'hFFFF_FFFF);
        chk("oor_rdy", bus_ready, 1);
        chk("oor_err", bus_err, 1);
        chk("oor_rdata", bus_rdata, 0);
        chk("oor_stb", wr_strobe, 0);
        chk("oor_keep", reg_q, snap);
        tick();
        access(0, 7, 2'd0, 32'h0);
        chk("oor_rd_err", bus_err, 1);
        chk("oor_rd_data", bus_rdata, 0);
        tick();

        access(1, 0, 2'd0, 32'hABCD_1234); tick();
        access(0, 0, 2'd1, 32'h0);
        chk("zext_rdata", bus_rdata, 32'h0000_1234);
        tick();

        access(1, 1, 2'd0, 32'h0000_0055);
        #1 rst = 1;
        #1;
        chk("midrst_rdy", bus_ready, 0);
        chk("midrst_q", reg_q, RESET_VALS);
        tick();
        rst = 0;
        access(1, 0, 2'd0, 32'h0000_0001);
        chk("post_rst_rdy", bus_ready, 1);
        chk("post_rst_val", rq(0), 16'h0001);
        tick();

        repeat (3000) begin
            bus_req   = ($urandom_range(0, 9) < 6);
            bus_we    = $urandom_range(0, 1) == 1;
            bus_addr  = AW'($urandom);
            bus_wdata = $urandom;
            for (int i = 0; i < NR; i++) begin
                hw_set[i*DW +: DW] = DW'($urandom & $urandom & $urandom);
                hw_ro[i*DW +: DW]  = DW'($urandom);
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 0; bus_req = 0; hw_set = 0;
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
